// File: rtl/seg7_to_bin.sv
// seg7_to_bin: recovers hex nibbles and bytes from a two-digit multiplexed 7-segment bus (optional SEG7_ERR_COUNT_EN adds o_Err_Count)
module seg7_to_bin #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segments,
  input  logic       i_Digit_Sel,
  output logic [3:0] o_Nibble,
  output logic       o_Nibble_DV,
  output logic [7:0] o_Byte,
  output logic       o_Byte_DV,
  output logic       o_Invalid
`ifdef SEG7_ERR_COUNT_EN
  ,
  output logic [7:0] o_Err_Count
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_LO, S_HI} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  state_t     state;
  logic [7:0] sync1, sync2, prev, cnt, cnt_next;
  logic [3:0] lo, hi, hex_val;
  logic       same, accept, hex_hit, sel, complete, emit, blank, bad;

  // run-length filter: accept once when the run of identical samples first reaches STABLE
  always_comb begin
    same     = sync2 == prev;
    cnt_next = same ? (cnt == STABLE ? cnt : cnt + 8'd1) : 8'd1;
    accept   = cnt_next == STABLE && !(same && cnt == STABLE);
    sel      = sync2[7];
    blank    = sync2[6:0] == 7'h00;
  end

  // reverse lookup of the segment pattern in the hex table
  always_comb begin
    hex_hit = 1'b0;
    hex_val = 4'h0;
    for (int i = 0; i < 16; i++)
      if (sync2[6:0] == SEG_TABLE[i]) begin
        hex_hit = 1'b1;
        hex_val = 4'(i);
      end
    complete = (state == S_LO && sel) || (state == S_HI && !sel);
    bad      = accept && !blank && !hex_hit;
  end

  // synchronizer, filter state, nibble decode, byte pairing FSM and strobes
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      cnt         <= '0;
      state       <= S_EMPTY;
      lo          <= '0;
      hi          <= '0;
      emit        <= 1'b0;
      o_Nibble    <= '0;
      o_Nibble_DV <= 1'b0;
      o_Byte      <= '0;
      o_Byte_DV   <= 1'b0;
      o_Invalid   <= 1'b0;
    end else begin
      sync1       <= {i_Digit_Sel, i_Segments};
      sync2       <= sync1;
      prev        <= sync2;
      cnt         <= cnt_next;
      o_Nibble_DV <= 1'b0;
      emit        <= 1'b0;
      o_Byte_DV   <= emit;
      if (emit) o_Byte <= {hi, lo};
      if (accept && !blank && hex_hit) begin
        o_Nibble    <= hex_val;
        o_Nibble_DV <= 1'b1;
        o_Invalid   <= 1'b0;
        if (sel) hi <= hex_val;
        else     lo <= hex_val;
        emit  <= complete;
        state <= complete ? S_EMPTY : (sel ? S_HI : S_LO);
      end else if (bad) begin
        o_Invalid <= 1'b1;
        state     <= S_EMPTY;
      end
    end

`ifdef SEG7_ERR_COUNT_EN
  // saturating count of accepted non-hex patterns
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) o_Err_Count <= '0;
    else if (bad && o_Err_Count != 8'hFF) o_Err_Count <= o_Err_Count + 8'd1;
`endif

endmodule

// File: tb/tb_seg7_to_bin.sv
// tb_seg7_to_bin: randomized and directed checks of seg7_to_bin against a behavioural model
module tb_seg7_to_bin;
  localparam int S = 4;

  logic       clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic [6:0] seg = 7'h00;
  logic [3:0] nibble;
  logic       nibble_dv, byte_dv, invalid;
  logic [7:0] byte_out, err_obs;
  logic [22:0] obs, expv;

  seg7_to_bin #(.STABLE_CYCLES(S)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Segments(seg), .i_Digit_Sel(sel),
    .o_Nibble(nibble), .o_Nibble_DV(nibble_dv), .o_Byte(byte_out),
    .o_Byte_DV(byte_dv), .o_Invalid(invalid)
`ifdef SEG7_ERR_COUNT_EN
    , .o_Err_Count(err_obs)
`endif
  );
`ifndef SEG7_ERR_COUNT_EN
  assign err_obs = 8'h00;
`endif

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic [3:0] m_nib, lo_v, hi_v;
  logic       m_ndv, m_bdv, m_inv;
  logic [7:0] m_byte, m_err, last_x;
  bit         have_lo, have_hi;
  int         run, cyc, vectors = 0, fails = 0;
  logic [7:0] acc_at [int];
  logic [7:0] byte_at [int];

  assign obs  = {nibble, nibble_dv, byte_out, byte_dv, invalid, err_obs};
  assign expv = {m_nib, m_ndv, m_byte, m_bdv, m_inv, m_err};

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset;
    m_nib = 0; m_ndv = 0; m_byte = 0; m_bdv = 0; m_inv = 0; m_err = 0;
    have_lo = 0; have_hi = 0; lo_v = 0; hi_v = 0; last_x = 0; run = 0;
    acc_at.delete(); byte_at.delete();
  endtask

  // drive one sample, advance one clock and update the model
  task automatic cycle(input logic s, input logic [6:0] p);
    logic [7:0] x;
    int v;
    sel = s; seg = p; x = {s, p};
    @(posedge clk);
    cyc++;
    run = (x == last_x) ? run + 1 : 1;
    last_x = x;
    if (run == S) acc_at[cyc + 2] = x;
    m_ndv = 0; m_bdv = 0;
    if (byte_at.exists(cyc)) begin
      m_byte = byte_at[cyc]; m_bdv = 1; byte_at.delete(cyc);
    end
    if (acc_at.exists(cyc)) begin
      x = acc_at[cyc]; acc_at.delete(cyc);
      v = lookup(x[6:0]);
      if (x[6:0] != 7'h00) begin
        if (v < 0) begin
          m_inv = 1; have_lo = 0; have_hi = 0;
`ifdef SEG7_ERR_COUNT_EN
          if (m_err != 8'hFF) m_err++;
`endif
        end else begin
          m_nib = 4'(v); m_ndv = 1; m_inv = 0;
          if (x[7]) begin
            if (have_lo) begin byte_at[cyc + 1] = {4'(v), lo_v}; have_lo = 0; end
            else begin have_hi = 1; hi_v = 4'(v); end
          end else begin
            if (have_hi) begin byte_at[cyc + 1] = {hi_v, 4'(v)}; have_hi = 0; end
            else begin have_lo = 1; lo_v = 4'(v); end
          end
        end
      end
    end
    #1;
  endtask

  // asynchronous reset pulse between clock edges, presenting a new input meanwhile
  task automatic do_reset(input logic s, input logic [6:0] p);
    #2 rst_n = 1'b0;
    #1 model_reset();
    vectors++;
    if (obs !== 23'h0) begin fails++; $display("FAIL reset_async got %h exp 0", obs); end
    sel = s; seg = p;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 23'h0) begin fails++; $display("FAIL reset_hold got %h exp 0", obs); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 23'h0) begin fails++; $display("FAIL reset_state got %h exp 0", obs); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 7'h00);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL reset_idle cyc=%0d got %h exp %h", cyc, obs, expv); end
    end
  endtask

  task automatic test_single_hold;
    int ndv = 0, bdv = 0, at = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(0, 7'h30);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL hold cyc=%0d got %h exp %h", cyc, obs, expv); end
      if (nibble_dv) begin ndv++; at = i; end
      if (byte_dv) bdv++;
    end
    vectors++;
    if (ndv != 1 || at != S + 2 || nibble !== 4'h1 || bdv != 0) begin
      fails++; $display("FAIL hold_strobe got n=%0d at=%0d nib=%h b=%0d exp n=1 at=%0d nib=1 b=0", ndv, at, nibble, bdv, S + 2);
    end
  endtask

  task automatic test_pair;
    int last_n = 0, bat = 0, bdv = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= 6) cycle(0, 7'h79); else if (i <= 12) cycle(1, 7'h77); else cycle(0, 7'h00);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL pair cyc=%0d got %h exp %h", cyc, obs, expv); end
      if (nibble_dv) last_n = i;
      if (byte_dv) begin bdv++; bat = i; end
    end
    vectors++;
    if (bdv != 1 || bat != last_n + 1 || byte_out !== 8'hA3) begin
      fails++; $display("FAIL pair_byte got n=%0d at=%0d byte=%h exp n=1 at=%0d byte=a3", bdv, bat, byte_out, last_n + 1);
    end
  endtask

  task automatic test_glitch;
    int ndv = 0, inv = 0;
    for (int i = 1; i <= 19; i++) begin
      if (i <= 3) cycle(0, 7'h7E); else if (i <= 7) cycle(0, 7'h30); else cycle(0, 7'h00);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL glitch cyc=%0d got %h exp %h", cyc, obs, expv); end
      if (nibble_dv) ndv++;
      if (invalid) inv++;
    end
    vectors++;
    if (ndv != 1 || nibble !== 4'h1 || inv != 0) begin
      fails++; $display("FAIL glitch_strobe got n=%0d nib=%h inv=%0d exp n=1 nib=1 inv=0", ndv, nibble, inv);
    end
  endtask

  task automatic test_invalid;
    int inv = 0, bdv = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i <= 5) cycle(0, 7'h5B);
      else if (i <= 10) cycle(1, 7'h01);
      else if (i <= 15) cycle(1, 7'h6D);
      else if (i <= 20) cycle(0, 7'h4F);
      else cycle(0, 7'h00);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL invalid cyc=%0d got %h exp %h", cyc, obs, expv); end
      if (invalid) inv++;
      if (byte_dv) bdv++;
    end
    vectors++;
    if (inv == 0 || bdv != 1 || byte_out !== 8'h2E || invalid !== 1'b0) begin
      fails++; $display("FAIL invalid_seq got inv=%0d b=%0d byte=%h end_inv=%b exp inv>0 b=1 byte=2e end_inv=0", inv, bdv, byte_out, invalid);
    end
  endtask

  task automatic test_reset_mid;
    int ndv = 0, bdv = 0;
    for (int i = 0; i < 6; i++) cycle(0, 7'h70);
    do_reset(1, 7'h7B);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 7'h7B);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL reset_mid cyc=%0d got %h exp %h", cyc, obs, expv); end
      if (nibble_dv) ndv++;
      if (byte_dv) bdv++;
    end
    vectors++;
    if (ndv != 1 || bdv != 0 || nibble !== 4'h9) begin
      fails++; $display("FAIL reset_mid_pair got n=%0d b=%0d nib=%h exp n=1 b=0 nib=9", ndv, bdv, nibble);
    end
  endtask

  task automatic test_random;
    logic [6:0] p;
    logic s;
    int hold, k;
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 9);
      s = 1'($urandom_range(0, 1));
      if (k < 7) p = tbl[$urandom_range(0, 15)];
      else if (k == 7) p = 7'h00;
      else begin
        p = 7'($urandom_range(1, 127));
        while (lookup(p) >= 0) p = 7'($urandom_range(1, 127));
      end
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) begin
        cycle(s, p);
        vectors++;
        if (obs !== expv) begin fails++; $display("FAIL random cyc=%0d got %h exp %h", cyc, obs, expv); end
      end
    end
  endtask

  task automatic test_err_count;
    do_reset(0, 7'h00);
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < S; i++) cycle(0, (n % 2 == 0) ? 7'h01 : 7'h02);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 7'h00);
      vectors++;
      if (obs !== expv) begin fails++; $display("FAIL err3 cyc=%0d got %h exp %h", cyc, obs, expv); end
    end
    vectors++;
`ifdef SEG7_ERR_COUNT_EN
    if (err_obs !== 8'd3) begin fails++; $display("FAIL err_count3 got %0d exp 3", err_obs); end
`else
    if (invalid !== 1'b1) begin fails++; $display("FAIL err_inv3 got %b exp 1", invalid); end
`endif
    for (int n = 0; n < 300; n++)
      for (int i = 0; i < S; i++) begin
        cycle(1, (n % 2 == 0) ? 7'h01 : 7'h02);
        vectors++;
        if (obs !== expv) begin fails++; $display("FAIL err_sat cyc=%0d got %h exp %h", cyc, obs, expv); end
      end
    repeat (3) cycle(1, 7'h00);
    vectors++;
`ifdef SEG7_ERR_COUNT_EN
    if (err_obs !== 8'd255) begin fails++; $display("FAIL err_count255 got %0d exp 255", err_obs); end
`else
    if (err_obs !== 8'd0) begin fails++; $display("FAIL err_absent got %0d exp 0", err_obs); end
`endif
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_single_hold();
    test_pair();
    test_glitch();
    test_invalid();
    test_reset_mid();
    test_random();
    test_err_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
